// File: rtl/iotgen_pkg.sv
// Shared types and constants for the PDP-8/I IOT pulse generator.
package iotgen_pkg;

  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 2;
  localparam int TIMER_W     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    G1   = 3'd2,
    S2   = 3'd3,
    G2   = 3'd4,
    S4   = 3'd5,
    G4   = 3'd6,
    DONE = 3'd7
  } iot_state_e;

  // Lowest enabled slot in a select mask; DONE when nothing is left to pulse.
  function automatic iot_state_e first_slot(input logic [2:0] sel);
    iot_state_e nxt;
    if (sel[0]) begin
      nxt = S1;
    end else if (sel[1]) begin
      nxt = S2;
    end else if (sel[2]) begin
      nxt = S4;
    end else begin
      nxt = DONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/iot_slot_timer.sv
// Loadable down-counter that times each slot/gap state; holds at zero.
module iot_slot_timer
  import iotgen_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Load on state entry, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {TIMER_W{1'b0}}) begin
      cnt_d = cnt_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {TIMER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {TIMER_W{1'b0}});

endmodule

// File: rtl/iot_pulse_gen.sv
// IOP1/IOP2/IOP4 pulse sequencer for PDP-8/I IOT instructions.
// Define IOTGEN_SKIP_EMPTY_EN to skip slots (and their gaps) whose select bit is 0.
module iot_pulse_gen
  import iotgen_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] iop_sel,
  input  logic       io_skip,
  input  logic       io_ac_clr,
  output logic       iop1,
  output logic       iop2,
  output logic       iop4,
  output logic       busy,
  output logic       done,
  output logic       skip_req,
  output logic       ac_clr_req
);

  localparam logic [TIMER_W-1:0] SLOT_LD = TIMER_W'(PULSE_W - 1);
  localparam logic [TIMER_W-1:0] GAP_LD  = TIMER_W'(GAP_W - 1);

  iot_state_e         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               skip_q, skip_d, acclr_q, acclr_d;
  logic               iop1_q, iop1_d, iop2_q, iop2_d, iop4_q, iop4_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               accept_s, slot_last_s, tmr_load_s, tmr_zero_s;
  logic [TIMER_W-1:0] tmr_val_s;

  iot_slot_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'b000;
      skip_q  <= 1'b0;
      acclr_q <= 1'b0;
      iop1_q  <= 1'b0;
      iop2_q  <= 1'b0;
      iop4_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      skip_q  <= skip_d;
      acclr_q <= acclr_d;
      iop1_q  <= iop1_d;
      iop2_q  <= iop2_d;
      iop4_q  <= iop4_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing; each timed state advances once its timer reads zero.
  always_comb begin
    accept_s = (state_q == IDLE) && start;
    state_d  = state_q;
    case (state_q)
`ifdef IOTGEN_SKIP_EMPTY_EN
      IDLE: state_d = accept_s ? first_slot(iop_sel) : IDLE;
      G1:   state_d = tmr_zero_s ? first_slot({sel_q[2], sel_q[1], 1'b0}) : G1;
      G2:   state_d = tmr_zero_s ? first_slot({sel_q[2], 2'b00}) : G2;
`else
      IDLE: state_d = accept_s ? S1 : IDLE;
      G1:   state_d = tmr_zero_s ? S2 : G1;
      G2:   state_d = tmr_zero_s ? S4 : G2;
`endif
      S1:   state_d = tmr_zero_s ? G1 : S1;
      S2:   state_d = tmr_zero_s ? G2 : S2;
      S4:   state_d = tmr_zero_s ? G4 : S4;
      G4:   state_d = tmr_zero_s ? DONE : G4;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer reload on every state change, select latch and return sampling.
  always_comb begin
    tmr_load_s  = (state_d != state_q);
    case (state_d)
      S1, S2, S4: tmr_val_s = SLOT_LD;
      G1, G2, G4: tmr_val_s = GAP_LD;
      default:    tmr_val_s = {TIMER_W{1'b0}};
    endcase
    slot_last_s = tmr_zero_s && ((state_q == S1) || (state_q == S2) || (state_q == S4));
    sel_d = accept_s ? iop_sel : sel_q;
    if (accept_s) begin
      skip_d  = 1'b0;
      acclr_d = 1'b0;
    end else if (slot_last_s) begin
      skip_d  = skip_q | io_skip;
      acclr_d = acclr_q | io_ac_clr;
    end else begin
      skip_d  = skip_q;
      acclr_d = acclr_q;
    end
  end

  // Outputs decoded from the next state so the flops line up with the state.
  always_comb begin
    iop1_d = (state_d == S1) && sel_d[0];
    iop2_d = (state_d == S2) && sel_d[1];
    iop4_d = (state_d == S4) && sel_d[2];
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign iop1       = iop1_q;
  assign iop2       = iop2_q;
  assign iop4       = iop4_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign skip_req   = skip_q;
  assign ac_clr_req = acclr_q;

endmodule

// File: tb/tb_iot_pulse_gen.sv
// Scoreboard bench for iot_pulse_gen: stimulus queues expected per-cycle outputs, a monitor checks them.
module tb_iot_pulse_gen;

  typedef struct {
    logic [6:0] exp;
    int         tc;
    int         cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, skip = 1'b0, acclr = 1'b0;
  logic [2:0] sel = 3'b000;
  logic rst2 = 1'b1, start2 = 1'b0, skip2 = 1'b0, acclr2 = 1'b0;
  logic [2:0] sel2 = 3'b000;
  logic o1_iop1, o1_iop2, o1_iop4, o1_busy, o1_done, o1_skip, o1_ac;
  logic o2_iop1, o2_iop2, o2_iop4, o2_busy, o2_done, o2_skip, o2_ac;

  exp_t q1[$];
  exp_t q2[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iot_pulse_gen dut (
    .clk(clk), .rst(rst), .start(start), .iop_sel(sel), .io_skip(skip), .io_ac_clr(acclr),
    .iop1(o1_iop1), .iop2(o1_iop2), .iop4(o1_iop4), .busy(o1_busy), .done(o1_done),
    .skip_req(o1_skip), .ac_clr_req(o1_ac)
  );

  iot_pulse_gen #(.PULSE_W(1), .GAP_W(1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .iop_sel(sel2), .io_skip(skip2), .io_ac_clr(acclr2),
    .iop1(o2_iop1), .iop2(o2_iop2), .iop4(o2_iop4), .busy(o2_busy), .done(o2_done),
    .skip_req(o2_skip), .ac_clr_req(o2_ac)
  );

  function automatic logic w(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Expected vector order: {iop1, iop2, iop4, busy, done, skip_req, ac_clr_req}
  function automatic logic [6:0] pk(input logic a, input logic b, input logic c, input logic d,
                                    input logic e, input logic f, input logic g);
    return {a, b, c, d, e, f, g};
  endfunction

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic tick(input bit d2, input logic st, input logic [2:0] s, input logic sk,
                      input logic ac, input logic r, input logic [6:0] exp, input int tc, input int cy);
    exp_t e;
    if (d2) begin
      start2 = st; sel2 = s; skip2 = sk; acclr2 = ac; rst2 = r;
      start = 1'b0; skip = 1'b0; acclr = 1'b0; rst = 1'b0;
    end else begin
      start = st; sel = s; skip = sk; acclr = ac; rst = r;
    end
    @(posedge clk);
    #1;
    e.exp = exp; e.tc = tc; e.cy = cy;
    if (d2) q2.push_back(e);
    else    q1.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queued expectations mid-cycle.
  initial begin
    exp_t e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        got = {o1_iop1, o1_iop2, o1_iop4, o1_busy, o1_done, o1_skip, o1_ac};
        n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL dut t%0d c%0d: got %b want %b", e.tc, e.cy, got, e.exp);
        end
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        got = {o2_iop1, o2_iop2, o2_iop4, o2_busy, o2_done, o2_skip, o2_ac};
        n_cmp++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL dut2 t%0d c%0d: got %b want %b", e.tc, e.cy, got, e.exp);
        end
      end
    end
  end

  initial begin
    int c, d;
    logic [6:0] x;

    // t0: reset held together with start -> everything stays 0
    for (int k = 0; k < 2; k++) tick(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 7'b0, 0, k + 1);

    // t1: sel 111, skip on last S2 cycle (10), ac_clr in a gap (11)
    for (int k = 0; k < 22; k++) begin
      c = k + 1;
      x = pk(w(c, 1, 4), w(c, 7, 10), w(c, 13, 16), w(c, 1, 19), c == 19, c >= 11, 1'b0);
      tick(1'b0, k == 0, 3'b111, k == 10, k == 11, 1'b0, x, 1, c);
    end

    // t2: sel 010, ac_clr on cycle 4, skip on cycle 6 (gap)
    for (int k = 0; k < 22; k++) begin
      c = k + 1;
`ifdef IOTGEN_SKIP_EMPTY_EN
      x = pk(1'b0, w(c, 1, 4), 1'b0, w(c, 1, 7), c == 7, 1'b0, c >= 5);
`else
      x = pk(1'b0, w(c, 7, 10), 1'b0, w(c, 1, 19), c == 19, 1'b0, c >= 5);
`endif
      tick(1'b0, k == 0, 3'b010, k == 6, k == 4, 1'b0, x, 2, c);
    end

    // t3: sel 001, ignored start with sel 110 at cycle 5, skip on cycle 16
    for (int k = 0; k < 22; k++) begin
      c = k + 1;
`ifdef IOTGEN_SKIP_EMPTY_EN
      x = pk(w(c, 1, 4), 1'b0, 1'b0, w(c, 1, 7), c == 7, 1'b0, 1'b0);
`else
      x = pk(w(c, 1, 4), 1'b0, 1'b0, w(c, 1, 19), c == 19, c >= 17, 1'b0);
`endif
      tick(1'b0, (k == 0) || (k == 5), (k == 0) ? 3'b001 : 3'b110, k == 16, 1'b0, 1'b0, x, 3, c);
    end

    // t4: sel 111, skip on cycle 4, reset on cycle 8, restart on cycle 10
    for (int k = 0; k < 32; k++) begin
      c = k + 1;
      d = c - 10;
      if (c <= 8)       x = pk(w(c, 1, 4), w(c, 7, 10), 1'b0, 1'b1, 1'b0, c >= 5, 1'b0);
      else if (c <= 10) x = 7'b0;
      else              x = pk(w(d, 1, 4), w(d, 7, 10), w(d, 13, 16), w(d, 1, 19), d == 19, 1'b0, 1'b0);
      tick(1'b0, (k == 0) || (k == 10), 3'b111, k == 4, 1'b0, k == 8, x, 4, c);
    end

    // t5: sel 000
    for (int k = 0; k < 22; k++) begin
      c = k + 1;
`ifdef IOTGEN_SKIP_EMPTY_EN
      x = pk(1'b0, 1'b0, 1'b0, c == 1, c == 1, 1'b0, 1'b0);
`else
      x = pk(1'b0, 1'b0, 1'b0, w(c, 1, 19), c == 19, 1'b0, 1'b0);
`endif
      tick(1'b0, k == 0, 3'b000, 1'b0, 1'b0, 1'b0, x, 5, c);
    end

    // t6: PULSE_W=GAP_W=1, sel 101, ac_clr on cycle 2 (gap), skip on cycle 3
    tick(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0, 6, 0);
    for (int k = 0; k < 10; k++) begin
      c = k + 1;
`ifdef IOTGEN_SKIP_EMPTY_EN
      x = pk(c == 1, 1'b0, c == 3, w(c, 1, 5), c == 5, c >= 4, 1'b0);
`else
      x = pk(c == 1, 1'b0, c == 5, w(c, 1, 7), c == 7, c >= 4, 1'b0);
`endif
      tick(1'b1, k == 0, 3'b101, k == 3, k == 2, 1'b0, x, 6, c);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if ((q1.size() != 0) || (q2.size() != 0)) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d queued want 0/0", q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
